// File: rtl/game_of_life_engine.sv
// Conway B3/S23 cellular automaton over a ROWS x COLS grid; optional toroidal wrap via macro LIFE_TORUS_EN.
// Latency: load visible after one edge; each applied generation visible after the edge that applies it.
// No backpressure: run is a level, step a one-cycle pulse, load always wins; grid_evolve is combinational.
module game_of_life_engine #(
   parameter int ROWS = 8,
   parameter int COLS = 8,
   parameter int GW   = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 load,
   input  logic [ROWS*COLS-1:0] seed,
   input  logic                 run,
   input  logic                 step,
   output logic [ROWS*COLS-1:0] grid,
   output logic [ROWS*COLS-1:0] grid_evolve,
   output logic [GW-1:0]        gen_count,
   output logic [1:0]           state,
   output logic                 stable,
   output logic                 extinct
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] PAUSE = 2'd1;
   localparam logic [1:0] RUN   = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

`ifdef LIFE_TORUS_EN
   localparam bit WRAP = 1'b1;
`else
   localparam bit WRAP = 1'b0;
`endif

   // Row 0 / col 0 live at the MSB end of the flattened vector.
   function automatic int bit_of(input int r, input int c);
      return (ROWS - 1 - r) * COLS + (COLS - 1 - c);
   endfunction

   for (genvar r = 0; r < ROWS; r++) begin : g_row
      for (genvar c = 0; c < COLS; c++) begin : g_col
         // Neighbour coordinates are always wrapped so every index stays in range;
         // in the bounded build the edge flags force off-grid neighbours to dead.
         localparam int RU  = (r + ROWS - 1) % ROWS;
         localparam int RD  = (r + 1) % ROWS;
         localparam int CL  = (c + COLS - 1) % COLS;
         localparam int CR  = (c + 1) % COLS;
         localparam bit OKU = WRAP || (r > 0);
         localparam bit OKD = WRAP || (r < ROWS - 1);
         localparam bit OKL = WRAP || (c > 0);
         localparam bit OKR = WRAP || (c < COLS - 1);

         logic [7:0] nb;
         logic [3:0] cnt;

         assign nb[0] = (OKU && OKL) ? grid[bit_of(RU, CL)] : 1'b0;
         assign nb[1] =  OKU         ? grid[bit_of(RU, c )] : 1'b0;
         assign nb[2] = (OKU && OKR) ? grid[bit_of(RU, CR)] : 1'b0;
         assign nb[3] =  OKL         ? grid[bit_of(r,  CL)] : 1'b0;
         assign nb[4] =  OKR         ? grid[bit_of(r,  CR)] : 1'b0;
         assign nb[5] = (OKD && OKL) ? grid[bit_of(RD, CL)] : 1'b0;
         assign nb[6] =  OKD         ? grid[bit_of(RD, c )] : 1'b0;
         assign nb[7] = (OKD && OKR) ? grid[bit_of(RD, CR)] : 1'b0;

         // Population count of the eight neighbours.
         always_comb begin
            cnt = 4'd0;
            for (int i = 0; i < 8; i++) begin
               cnt = cnt + {3'b000, nb[i]};
            end
         end

         assign grid_evolve[bit_of(r, c)] = (cnt == 4'd3) || (grid[bit_of(r, c)] && (cnt == 4'd2));
      end
   end

   assign extinct = (grid == '0);

   logic same;
   assign same = (grid_evolve == grid);

   // Control FSM plus grid/counter/stable registers; load overrides every state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         grid      <= '0;
         gen_count <= '0;
         stable    <= 1'b0;
         state     <= IDLE;
      end else if (load) begin
         grid      <= seed;
         gen_count <= '0;
         stable    <= 1'b0;
         state     <= PAUSE;
      end else begin
         case (state)
            PAUSE: begin
               // run takes precedence; a coincident step is dropped.
               if (run) begin
                  state <= RUN;
               end else if (step) begin
                  grid      <= grid_evolve;
                  gen_count <= (gen_count == '1) ? gen_count : gen_count + 1'b1;
                  stable    <= same;
                  if (same) state <= DONE;
               end
            end
            RUN: begin
               if (!run) begin
                  state <= PAUSE;
               end else begin
                  grid      <= grid_evolve;
                  gen_count <= (gen_count == '1) ? gen_count : gen_count + 1'b1;
                  stable    <= same;
                  if (same) state <= DONE;
               end
            end
            default: begin
               // IDLE and DONE hold everything until a load.
            end
         endcase
      end
   end

endmodule

// File: tb/tb_game_of_life_engine.sv
module tb_game_of_life_engine;

   localparam int ROWS = 8;
   localparam int COLS = 8;
   localparam int GW   = 4;
   localparam int N    = ROWS * COLS;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_PAUSE = 2'd1;
   localparam logic [1:0] S_RUN   = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

`ifdef LIFE_TORUS_EN
   localparam bit WRAP = 1'b1;
`else
   localparam bit WRAP = 1'b0;
`endif

   localparam logic [N-1:0] BLINK_H = 64'h0000_0000_3800_0000;
   localparam logic [N-1:0] BLINK_V = 64'h0000_0010_1010_0000;
   localparam logic [N-1:0] BLOCK   = 64'h0000_0018_1800_0000;
   localparam logic [N-1:0] SINGLE  = 64'h0000_0000_0800_0000;
   localparam logic [N-1:0] GLIDER  = 64'h4020_E000_0000_0000;

   logic          clk   = 1'b0;
   logic          reset = 1'b0;
   logic          load  = 1'b0;
   logic          run   = 1'b0;
   logic          step  = 1'b0;
   logic [N-1:0]  seed  = '0;
   logic [N-1:0]  grid;
   logic [N-1:0]  grid_evolve;
   logic [GW-1:0] gen_count;
   logic [1:0]    state;
   logic          stable;
   logic          extinct;

   game_of_life_engine #(.ROWS(ROWS), .COLS(COLS), .GW(GW)) dut (
      .clk         (clk),
      .reset       (reset),
      .load        (load),
      .seed        (seed),
      .run         (run),
      .step        (step),
      .grid        (grid),
      .grid_evolve (grid_evolve),
      .gen_count   (gen_count),
      .state       (state),
      .stable      (stable),
      .extinct     (extinct)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [N-1:0]  g;
      logic [GW-1:0] gen;
      logic [1:0]    st;
      logic          stb;
   } exp_t;

   exp_t sb[$];

   // Reference model state.
   logic [N-1:0]  mg;
   logic [GW-1:0] mgen;
   logic [1:0]    ms;
   logic          mstb;

   int n_checks = 0;
   int n_fail   = 0;

   // Straightforward B3/S23 reference over an 8x8 grid.
   function automatic logic [N-1:0] life(input logic [N-1:0] g);
      logic [N-1:0] nx;
      nx = '0;
      for (int r = 0; r < ROWS; r++) begin
         for (int c = 0; c < COLS; c++) begin
            int n;
            n = 0;
            for (int dr = -1; dr <= 1; dr++) begin
               for (int dc = -1; dc <= 1; dc++) begin
                  int rr;
                  int cc;
                  rr = r + dr;
                  cc = c + dc;
                  if (WRAP) begin
                     rr = (rr + ROWS) % ROWS;
                     cc = (cc + COLS) % COLS;
                  end
                  if (!(dr == 0 && dc == 0) && rr >= 0 && rr < ROWS && cc >= 0 && cc < COLS)
                     n = n + int'(g[(ROWS-1-rr)*COLS + (COLS-1-cc)]);
               end
            end
            nx[(ROWS-1-r)*COLS + (COLS-1-c)] = (n == 3) || (g[(ROWS-1-r)*COLS + (COLS-1-c)] && n == 2);
         end
      end
      return nx;
   endfunction

   task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mg   = '0;
      mgen = '0;
      ms   = S_IDLE;
      mstb = 1'b0;
   endtask

   task automatic model_apply();
      logic [N-1:0] nx;
      nx   = life(mg);
      mstb = (nx == mg);
      if (nx == mg) ms = S_DONE;
      mg   = nx;
      if (mgen != {GW{1'b1}}) mgen = mgen + 1'b1;
   endtask

   // One clock: drive inputs, push the predicted post-edge state, compare after the edge.
   task automatic tick(input logic ld, input logic [N-1:0] sd, input logic rn, input logic st);
      exp_t e;
      exp_t o;
      load = ld;
      seed = sd;
      run  = rn;
      step = st;
      if (ld) begin
         mg = sd; mgen = '0; mstb = 1'b0; ms = S_PAUSE;
      end else begin
         case (ms)
            S_PAUSE: if (rn) ms = S_RUN; else if (st) model_apply();
            S_RUN:   if (!rn) ms = S_PAUSE; else model_apply();
            default: ;
         endcase
      end
      e.g = mg; e.gen = mgen; e.st = ms; e.stb = mstb;
      sb.push_back(e);
      @(posedge clk);
      #1;
      o = sb.pop_front();
      check("grid",        grid, o.g);
      check("gen_count",   {{(N-GW){1'b0}}, gen_count}, {{(N-GW){1'b0}}, o.gen});
      check("state",       {{(N-2){1'b0}}, state}, {{(N-2){1'b0}}, o.st});
      check("stable",      {{(N-1){1'b0}}, stable}, {{(N-1){1'b0}}, o.stb});
      check("extinct",     {{(N-1){1'b0}}, extinct}, {{(N-1){1'b0}}, (o.g == '0)});
      check("grid_evolve", grid_evolve, life(o.g));
      load = 1'b0;
      step = 1'b0;
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_grid"},    grid, '0);
      check({tag, "_gen"},     {{(N-GW){1'b0}}, gen_count}, '0);
      check({tag, "_state"},   {{(N-2){1'b0}}, state}, {{(N-2){1'b0}}, S_IDLE});
      check({tag, "_stable"},  {{(N-1){1'b0}}, stable}, '0);
      check({tag, "_extinct"}, {{(N-1){1'b0}}, extinct}, {{(N-1){1'b0}}, 1'b1});
      check({tag, "_evolve"},  grid_evolve, '0);
   endtask

   initial begin
      // Reset asserted from time 0: outputs must already be cleared.
      model_reset();
      #2;
      check_reset_values("por");
      #1 reset = 1'b1;
      @(posedge clk);
      #1;

      // IDLE ignores run and step.
      tick(1'b0, '0, 1'b1, 1'b1);
      tick(1'b0, '0, 1'b0, 1'b1);

      // Blinker: oscillates, never stable, counter saturates at 4 bits.
      tick(1'b1, BLINK_H, 1'b0, 1'b0);
      check("blink_loaded", grid, BLINK_H);
      tick(1'b0, '0, 1'b1, 1'b0);
      check("blink_enter_run", grid, BLINK_H);
      tick(1'b0, '0, 1'b1, 1'b0);
      check("blink_vertical", grid, BLINK_V);
      for (int i = 0; i < 19; i++) tick(1'b0, '0, 1'b1, 1'b0);
      check("blink_saturated", {{(N-GW){1'b0}}, gen_count}, {{(N-GW){1'b0}}, {GW{1'b1}}});
      tick(1'b0, '0, 1'b0, 1'b0);

      // step together with run in PAUSE: go to RUN, drop the step.
      tick(1'b0, '0, 1'b1, 1'b1);
      tick(1'b0, '0, 1'b0, 1'b0);

      // Block still life goes to DONE on the first applied generation.
      tick(1'b1, BLOCK, 1'b0, 1'b0);
      tick(1'b0, '0, 1'b1, 1'b0);
      tick(1'b0, '0, 1'b1, 1'b0);
      check("block_state", {{(N-2){1'b0}}, state}, {{(N-2){1'b0}}, S_DONE});
      check("block_gen",   {{(N-GW){1'b0}}, gen_count}, {{(N-GW){1'b0}}, 4'd1});
      tick(1'b0, '0, 1'b1, 1'b1);
      check("block_hold",  grid, BLOCK);

      // Single cell dies on one step; a second step reaches DONE.
      tick(1'b1, SINGLE, 1'b0, 1'b0);
      tick(1'b0, '0, 1'b0, 1'b1);
      check("single_dead", grid, '0);
      tick(1'b0, '0, 1'b0, 1'b1);
      check("single_done", {{(N-2){1'b0}}, state}, {{(N-2){1'b0}}, S_DONE});
      check("single_gen2", {{(N-GW){1'b0}}, gen_count}, {{(N-GW){1'b0}}, 4'd2});

      // load with step: load wins.
      tick(1'b1, GLIDER, 1'b0, 1'b1);
      check("loadstep_grid", grid, GLIDER);
      check("loadstep_gen",  {{(N-GW){1'b0}}, gen_count}, '0);

      // Glider: full wrap on the torus, otherwise settles into a corner block.
      tick(1'b0, '0, 1'b1, 1'b0);
      if (WRAP) begin
         for (int i = 0; i < 32; i++) tick(1'b0, '0, 1'b1, 1'b0);
         check("glider_wrap", grid, GLIDER);
      end else begin
         for (int i = 0; i < 80 && ms != S_DONE; i++) tick(1'b0, '0, 1'b1, 1'b0);
         check("glider_done", {{(N-2){1'b0}}, state}, {{(N-2){1'b0}}, S_DONE});
      end

      // Asynchronous reset in the middle of RUN.
      tick(1'b1, BLINK_H, 1'b0, 1'b0);
      tick(1'b0, '0, 1'b1, 1'b0);
      tick(1'b0, '0, 1'b1, 1'b0);
      #1 reset = 1'b0;
      #1;
      check_reset_values("midrun");
      model_reset();
      #1 reset = 1'b1;
      tick(1'b0, '0, 1'b1, 1'b0);
      tick(1'b0, '0, 1'b1, 1'b0);
      check("post_reset_idle", {{(N-2){1'b0}}, state}, {{(N-2){1'b0}}, S_IDLE});

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
